// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared constants and FSM state encoding for the 4-channel
//               mux scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    localparam int NUM_CH = 4;   // channels behind the mux
    localparam int SEL_W  = 2;   // select width
    localparam int CNT_W  = 8;   // dwell counter width

    // 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCAN   = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/scan_next_channel.sv
`default_nettype none
// ============================================================================
// Module      : scan_next_channel
// Description : Combinational priority search over an enable mask.
//               first=1 : lowest set bit of mask_r.
//               first=0 : lowest set bit strictly above cur.
// Ports       : mask_r [NUM_CH] in  - enable mask being searched
//               cur    [SEL_W]  in  - current channel index
//               first           in  - search from the bottom of the mask
//               next   [SEL_W]  out - index found (0 when none)
//               found           out - a qualifying channel exists
// Revision    : 1.0 - initial release
// ============================================================================
module scan_next_channel
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_r,
    input  logic [SEL_W-1:0]  cur,
    input  logic              first,
    output logic [SEL_W-1:0]  next,
    output logic              found
);

    // Walk from the top down so the lowest qualifying index is the last
    // one written and therefore wins.
    always_comb begin
        next  = '0;
        found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask_r[k] && (first || (k > int'(cur)))) begin
                next  = SEL_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan_controller_4ch.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_controller_4ch
// Description : Drives the select lines of a 4:1 mux through the enabled
//               channels in ascending order, holds each select for DWELL
//               cycles and captures the mux output on the last cycle of each
//               window into q. One accepted start gives one scan, ended by a
//               one-cycle done pulse.
// Parameters  : DWELL - cycles per channel, 1..255
// Ports       : clk          in  - clock, rising edge
//               rst          in  - asynchronous active-high reset
//               start        in  - scan request, sampled in IDLE only
//               en   [4]     in  - channel enable mask, latched on start
//               y            in  - mux output
//               s    [2]     out - mux select (registered)
//               q    [4]     out - captured samples (registered)
//               busy         out - scan in progress (registered)
//               done         out - scan-complete pulse (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_controller_4ch
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] en,
    input  logic              y,
    output logic [SEL_W-1:0]  s,
    output logic [NUM_CH-1:0] q,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] C_DWELL_LAST = CNT_W'(DWELL - 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [NUM_CH-1:0] r_mask,  w_mask_nxt;
    logic [SEL_W-1:0]  r_s,     w_s_nxt;
    logic [NUM_CH-1:0] r_q,     w_q_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;

    // In IDLE the search runs on the live en so the first select can be
    // loaded on the same edge that latches the mask.
    logic [NUM_CH-1:0] w_srch_mask;
    logic              w_srch_first;
    logic [SEL_W-1:0]  w_srch_next;
    logic              w_srch_found;

    assign w_srch_first = (r_state == ST_IDLE);
    assign w_srch_mask  = w_srch_first ? en : r_mask;

    scan_next_channel u_next (
        .mask_r (w_srch_mask),
        .cur    (r_s),
        .first  (w_srch_first),
        .next   (w_srch_next),
        .found  (w_srch_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_s     <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            r_s     <= w_s_nxt;
            r_q     <= w_q_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_s_nxt     = r_s;
        w_q_nxt     = r_q;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mask_nxt = en;
                    if (w_srch_found) begin
                        w_state_nxt = ST_SCAN;
                        w_s_nxt     = w_srch_next;
                        w_cnt_nxt   = '0;
                    end else begin
                        // Empty mask: report completion without capturing.
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_SCAN: begin
                if (r_cnt == C_DWELL_LAST) begin
                    w_q_nxt[r_s] = y;
                    if (w_srch_found) begin
                        w_s_nxt   = w_srch_next;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_FINISH;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Registered status follows the state being entered.
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_FINISH);
    end

    assign s    = r_s;
    assign q    = r_q;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire
